// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the boot byte stream and the instruction-memory
// write port used by imem_loader.
//
// Handshake: a byte moves from source to loader on a rising clock edge where
// in_valid && in_ready are both high. The source holds in_data stable while
// in_valid is high and the byte has not yet transferred. in_ready is a pure
// function of loader state and never depends on in_valid.
//
// Signals:
//   in_data    [7:0]            stream byte (source -> loader)
//   in_valid                    in_data is valid (source -> loader)
//   in_ready                    loader accepts a byte (loader -> source)
//   imem_we                     one-cycle memory write strobe (loader -> memory)
//   imem_addr  [ADDR_WIDTH-1:0] word address of the write (loader -> memory)
//   imem_wdata [31:0]           word to write (loader -> memory)
//
// Modports: master = stream source / memory side, slave = the loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader for the 5-stage pipeline.
// Receives a framed byte stream (LEN_HI, LEN_LO, 4*N data bytes big-endian,
// CHK = XOR of all preceding frame bytes), writes each assembled 32-bit word
// to instruction memory, and holds the pipeline in reset until a complete,
// checksum-verified image has been loaded.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   bus          imem_loader_if.slave: byte stream + memory write port
//   load_start   one-cycle pulse; restarts loading from DONE or ERROR
//   cpu_reset    pipeline reset, high except in DONE
//   load_done    image loaded and verified
//   load_error   length or checksum failure
//   words_loaded number of words written in the current load
//   dbg_state_o  current FSM state (debug visibility)
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  input  logic          load_start,
  output logic          cpu_reset,
  output logic          load_done,
  output logic          load_error,
  output logic [15:0]   words_loaded,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  // Capacity in words; 17 bits so that 2**16 is representable.
  localparam logic [16:0] CAP_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            chk_q, chk_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;     // first three bytes of a word
  logic [15:0]           words_q, words_d;   // doubles as next write address
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  in_ready;
  logic                  accept;
  logic [16:0]           n_full;

  assign in_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DATA)   || (state_q == CHK);
  assign accept   = bus.in_valid && in_ready;
  // Full length as it will be once the low byte is latched this cycle.
  assign n_full   = {1'b0, len_q[15:8], bus.in_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    word_d  = word_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        state_d = LEN_HI;
        len_d   = '0;
        chk_d   = '0;
        idx_d   = '0;
        word_d  = '0;
        words_d = '0;
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.in_data;
          chk_d       = chk_q ^ bus.in_data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bus.in_data;
          chk_d      = chk_q ^ bus.in_data;
          if (n_full > CAP_WORDS) begin
            state_d = ERROR;
          end else if (n_full == 17'd0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          chk_d  = chk_q ^ bus.in_data;
          word_d = {word_q[15:0], bus.in_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_q[ADDR_WIDTH-1:0];
            wdata_d = {word_q, bus.in_data};
            words_d = words_q + 16'd1;
            // N <= capacity, so words_q + 1 cannot overflow here.
            if (words_q + 16'd1 == len_q) begin
              state_d = CHK;
            end
          end
        end
      end
      CHK: begin
        if (accept) begin
          chk_d   = chk_q ^ bus.in_data;
          state_d = (bus.in_data == chk_q) ? DONE : ERROR;
        end
      end
      DONE, ERROR: begin
        if (load_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they change the
    // cycle after the deciding byte is accepted.
    cpu_reset_d = (state_d != DONE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      words_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      words_q     <= words_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign load_done      = done_q;
  assign load_error     = error_q;
  assign words_loaded   = words_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for imem_loader. Expected memory
// writes are queued in exp_q and matched by a write monitor; status outputs
// are compared against hand-computed values.
module tb_imem_loader;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .load_start   (load_start),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+31:0] exp_q[$];   // {addr, wdata}
  logic [7:0]     frame[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the next queued write, and
  // words_loaded must already count that word.
  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexp_we", 64'(bus.imem_we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_addr",  64'(bus.imem_addr),  64'(e[AW+31:32]));
        check("we_data",  64'(bus.imem_wdata), 64'(e[31:0]));
        check("we_count", 64'(words_loaded),   64'(e[AW+31:32]) + 64'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("rdy_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic send_frame(input int gap);
    foreach (frame[i]) begin
      send_byte(frame[i]);
      if (gap > 0 && i < frame.size() - 1) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    check("restart_cpu_reset", 64'(cpu_reset), 64'd1);
    check("restart_done",      64'(load_done), 64'd0);
    check("restart_error",     64'(load_error), 64'd0);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic cpu_rst, input logic [15:0] words);
    check({tag, "_done"},      64'(load_done),    64'(done));
    check({tag, "_error"},     64'(load_error),   64'(err));
    check({tag, "_cpu_reset"}, 64'(cpu_reset),    64'(cpu_rst));
    check({tag, "_words"},     64'(words_loaded), 64'(words));
    check({tag, "_in_ready"},  64'(bus.in_ready), 64'd0);
    check({tag, "_pending"},   64'(exp_q.size()), 64'd0);
  endtask

  task automatic push_frame_a_writes();
    exp_q.push_back({8'h00, 32'h2008_0005});
    exp_q.push_back({8'h01, 32'h0000_0000});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b1;
    load_start   = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_in_ready",  64'(bus.in_ready),   64'd0);
    check("rst_we",        64'(bus.imem_we),    64'd0);
    check("rst_addr",      64'(bus.imem_addr),  64'd0);
    check("rst_wdata",     64'(bus.imem_wdata), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset),      64'd1);
    check("rst_done",      64'(load_done),      64'd0);
    check("rst_error",     64'(load_error),     64'd0);
    check("rst_words",     64'(words_loaded),   64'd0);
    reset = 1'b0;

    // Frame A, no gaps. CHK: 00^02^20^08^00^05 = 2F.
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
    push_frame_a_writes();
    send_frame(0);
    check_status("a_nogap", 1'b1, 1'b0, 1'b0, 16'd2);

    // Frame A with 3 idle cycles between every byte.
    pulse_start();
    push_frame_a_writes();
    send_frame(3);
    check_status("a_gap", 1'b1, 1'b0, 1'b0, 16'd2);

    // Frame A with a bad checksum: both writes, then ERROR.
    pulse_start();
    frame[10] = 8'h2E;
    push_frame_a_writes();
    send_frame(0);
    check_status("bad_chk", 1'b0, 1'b1, 1'b1, 16'd2);

    // Oversize length 0x0101 > 256: ERROR right after LEN_LO, no writes.
    pulse_start();
    frame = '{8'h01, 8'h01};
    send_frame(0);
    check_status("oversize", 1'b0, 1'b1, 1'b1, 16'd0);

    // Exactly capacity (0x0100) is legal: accepted into DATA, not ERROR.
    pulse_start();
    frame = '{8'h01, 8'h00};
    send_frame(0);
    check("cap_not_error", 64'(load_error),   64'd0);
    check("cap_in_ready",  64'(bus.in_ready), 64'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Empty image: 00 00 00 -> DONE with no writes.
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check_status("empty", 1'b1, 1'b0, 1'b0, 16'd0);

    // Reset mid-load: word 0 completes, word 1 is two bytes in when reset hits.
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};
    exp_q.push_back({8'h00, 32'h2008_0005});
    send_frame(0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_in_ready",  64'(bus.in_ready),   64'd0);
    check("mid_we",        64'(bus.imem_we),    64'd0);
    check("mid_addr",      64'(bus.imem_addr),  64'd0);
    check("mid_wdata",     64'(bus.imem_wdata), 64'd0);
    check("mid_cpu_reset", 64'(cpu_reset),      64'd1);
    check("mid_done",      64'(load_done),      64'd0);
    check("mid_words",     64'(words_loaded),   64'd0);
    check("mid_pending",   64'(exp_q.size()),   64'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_write",  64'(bus.imem_we),    64'd0);

    // Full resend after reset.
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
    push_frame_a_writes();
    send_frame(0);
    check_status("resend", 1'b1, 1'b0, 1'b0, 16'd2);

    // Reload a one-word image. CHK: 00^01^8C^09^00^04 = 80.
    pulse_start();
    frame = '{8'h00, 8'h01, 8'h8C, 8'h09, 8'h00, 8'h04, 8'h80};
    exp_q.push_back({8'h00, 32'h8C09_0004});
    send_frame(0);
    check_status("reload", 1'b1, 1'b0, 1'b0, 16'd1);

    // load_start while not in DONE/ERROR is ignored.
    pulse_start();
    @(posedge clk);
    #1;
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    check("ignored_start_ready", 64'(bus.in_ready), 64'd1);
    check("ignored_start_state", 64'(dbg_state),    64'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
